// File: rtl/alex_pkg.sv
// rtl/alex_pkg.sv - Alex LPF band codes, band thresholds, FSM state type and decoder
package alex_pkg;

    localparam int ALEX_WORD_BITS = 16;

    localparam logic [6:0] LPF_160   = 7'b0001000;
    localparam logic [6:0] LPF_80    = 7'b0000100;
    localparam logic [6:0] LPF_60_40 = 7'b0000010;
    localparam logic [6:0] LPF_30_20 = 7'b0000001;
    localparam logic [6:0] LPF_17_15 = 7'b1000000;
    localparam logic [6:0] LPF_12_10 = 7'b0100000;
    localparam logic [6:0] LPF_6     = 7'b0010000;

    localparam logic [31:0] F_10M  = 32'd29700000;
    localparam logic [31:0] F_15M  = 32'd21450000;
    localparam logic [31:0] F_20M  = 32'd14350000;
    localparam logic [31:0] F_40M  = 32'd7300000;
    localparam logic [31:0] F_80M  = 32'd4000000;
    localparam logic [31:0] F_160M = 32'd2000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_SHIFT,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    // Each threshold is the top edge of the lower band, so equality stays in the lower filter.
    function automatic logic [6:0] lpf_decode(input logic [31:0] f);
        if (f > F_10M)       return LPF_6;
        else if (f > F_15M)  return LPF_12_10;
        else if (f > F_20M)  return LPF_17_15;
        else if (f > F_40M)  return LPF_30_20;
        else if (f > F_80M)  return LPF_60_40;
        else if (f > F_160M) return LPF_80;
        else                 return LPF_160;
    endfunction

endpackage

// File: rtl/alex_spi_shift.sv
// rtl/alex_spi_shift.sv - shifts one Alex relay word MSB first, then pulses the load strobe
module alex_spi_shift
    import alex_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word,
    output logic        sclk,
    output logic        sdo,
    output logic        load,
    output logic        done
);

    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int DW      = $clog2(BIT_CYC + 1);

    logic          active_q, active_d;
    logic          load_q, load_d;
    logic [14:0]   shreg_q, shreg_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic          sdo_q, sdo_d;
    logic          last_div;

    assign last_div = (div_q == DW'(BIT_CYC - 1));

    always_comb begin
        active_d = active_q;
        load_d   = load_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        sdo_d    = sdo_q;
        if (start) begin
            active_d = 1'b1;
            load_d   = 1'b0;
            shreg_d  = word[14:0];
            div_d    = '0;
            bit_d    = 4'(ALEX_WORD_BITS - 1);
            sclk_d   = 1'b0;
            sdo_d    = word[15];
        end else if (active_q) begin
            if (!last_div) begin
                div_d  = div_q + DW'(1);
                sclk_d = !load_q && ((div_q + DW'(1)) >= DW'(CLK_DIV));
            end else begin
                div_d  = '0;
                sclk_d = 1'b0;
                if (load_q) begin
                    active_d = 1'b0;
                    load_d   = 1'b0;
                end else if (bit_q == 4'd0) begin
                    load_d = 1'b1;
                    sdo_d  = 1'b0;
                end else begin
                    bit_d   = bit_q - 4'd1;
                    sdo_d   = shreg_q[14];
                    shreg_d = {shreg_q[13:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            load_q   <= 1'b0;
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            load_q   <= load_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
        end
    end

    assign sclk = sclk_q;
    assign sdo  = sdo_q;
    assign load = load_q;
    assign done = active_q & load_q & last_div;

endmodule

// File: rtl/alex_lpf_sequencer.sv
// rtl/alex_lpf_sequencer.sv - picks the LPF band, gates TX and sequences the Alex relay update
module alex_lpf_sequencer
    import alex_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int GUARD_CYCLES  = 1000,
    parameter int SETTLE_CYCLES = 61440
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rx_frequency,
    input  logic [31:0] tx_frequency,
    input  logic        ptt,
    output logic [6:0]  LPF,
    output logic        tx_inhibit,
    output logic        busy,
    output logic        alex_sclk,
    output logic        alex_sdo,
    output logic        alex_load
);

    localparam int BIT_CYC  = 2 * CLK_DIV;
    localparam int MAX_GS   = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX  = (MAX_GS > BIT_CYC) ? MAX_GS : BIT_CYC;
    localparam int CW       = $clog2(CNT_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [6:0]    target_q, target_d;
    logic [6:0]    lpf_q, lpf_d;
    logic [6:0]    snap_q, snap_d;
    logic          pending_q, pending_d;
    logic          tx_inhibit_q, tx_inhibit_d;
    logic          busy_q, busy_d;
    logic          change;
    logic          spi_start;
    logic          spi_done;

    assign change = pending_q | (target_q != lpf_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        lpf_d        = lpf_q;
        snap_d       = snap_q;
        pending_d    = pending_q;
        tx_inhibit_d = tx_inhibit_q;
        spi_start    = 1'b0;
        target_d     = lpf_decode(ptt ? tx_frequency : rx_frequency);
        case (state_q)
            ST_IDLE: begin
                tx_inhibit_d = change;
                if (change) begin
                    state_d   = ST_INHIBIT;
                    pending_d = 1'b0;
                    cnt_d     = CW'(GUARD_CYCLES - 1);
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_SHIFT;
                    snap_d    = target_q;
                    spi_start = 1'b1;
                    cnt_d     = CW'(BIT_CYC - 1);
                    bit_d     = 4'(ALEX_WORD_BITS - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = CW'(BIT_CYC - 1);
                    if (bit_q == 4'd0) begin
                        state_d = ST_LOAD;
                        lpf_d   = snap_q;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_LOAD: begin
                if (spi_done) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                // A band change that arrived mid-transfer re-arms without releasing TX.
                if (cnt_q == '0) begin
                    if (target_q != lpf_q) begin
                        state_d = ST_INHIBIT;
                        cnt_d   = CW'(GUARD_CYCLES - 1);
                    end else begin
                        state_d      = ST_IDLE;
                        tx_inhibit_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            target_q     <= LPF_160;
            lpf_q        <= LPF_160;
            snap_q       <= LPF_160;
            pending_q    <= 1'b1;
            tx_inhibit_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            target_q     <= target_d;
            lpf_q        <= lpf_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            tx_inhibit_q <= tx_inhibit_d;
            busy_q       <= busy_d;
        end
    end

    alex_spi_shift #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .clock(clock),
        .reset(reset),
        .start(spi_start),
        .word ({9'b0, target_q}),
        .sclk (alex_sclk),
        .sdo  (alex_sdo),
        .load (alex_load),
        .done (spi_done)
    );

    assign LPF        = lpf_q;
    assign tx_inhibit = tx_inhibit_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alex_lpf_sequencer.sv
// tb/tb_alex_lpf_sequencer.sv - scoreboard bench for the Alex LPF sequencer
module tb_alex_lpf_sequencer;

    localparam int D     = 2;
    localparam int G     = 5;
    localparam int S     = 20;
    localparam int TOTAL = G + 34 * D + S;
    localparam int LIMIT = 1000;

    logic        clock;
    logic        reset;
    logic [31:0] rx_frequency;
    logic [31:0] tx_frequency;
    logic        ptt;
    logic [6:0]  LPF;
    logic        tx_inhibit;
    logic        busy;
    logic        alex_sclk;
    logic        alex_sdo;
    logic        alex_load;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_word_q[$];
    logic [6:0]  got_lpf_q[$];
    int          got_nb_q[$];

    logic [15:0] mon_sh;
    int          mon_nb;
    logic        mon_prev_sclk;
    logic        mon_prev_load;

    alex_lpf_sequencer #(
        .CLK_DIV(D),
        .GUARD_CYCLES(G),
        .SETTLE_CYCLES(S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_frequency(rx_frequency),
        .tx_frequency(tx_frequency),
        .ptt(ptt),
        .LPF(LPF),
        .tx_inhibit(tx_inhibit),
        .busy(busy),
        .alex_sclk(alex_sclk),
        .alex_sdo(alex_sdo),
        .alex_load(alex_load)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture side of the scoreboard: reassemble words from the serial pins.
    always @(negedge clock) begin
        if (reset) begin
            mon_sh        <= '0;
            mon_nb        <= 0;
            mon_prev_sclk <= 1'b0;
            mon_prev_load <= 1'b0;
        end else begin
            if (alex_sclk && !mon_prev_sclk) begin
                mon_sh <= {mon_sh[14:0], alex_sdo};
                mon_nb <= mon_nb + 1;
            end
            if (alex_load && !mon_prev_load) begin
                got_word_q.push_back(mon_sh);
                got_lpf_q.push_back(LPF);
                got_nb_q.push_back(mon_nb);
                mon_nb <= 0;
            end
            mon_prev_sclk <= alex_sclk;
            mon_prev_load <= alex_load;
        end
    end

    task automatic wait_busy(output bit ok);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        ok = busy;
    endtask

    task automatic measure(output int busy_n, output int inh_low, output int rises, output logic inh_after);
        logic prev = alex_sclk;
        busy_n = 0;
        inh_low = 0;
        rises = 0;
        while (busy && busy_n < LIMIT) begin
            busy_n++;
            if (!tx_inhibit) inh_low++;
            if (alex_sclk && !prev) rises++;
            prev = alex_sclk;
            @(negedge clock);
        end
        inh_after = tx_inhibit;
    endtask

    task automatic pop_word(output bit have, output logic [15:0] exp, output logic [15:0] got,
                            output logic [6:0] lpf, output int nb);
        have = (exp_q.size() > 0) && (got_word_q.size() > 0);
        exp = 16'hxxxx;
        got = 16'hxxxx;
        lpf = 7'hxx;
        nb = -1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        if (got_word_q.size() > 0) begin
            got = got_word_q.pop_front();
            lpf = got_lpf_q.pop_front();
            nb  = got_nb_q.pop_front();
        end
    endtask

    task automatic test_reset;
        bit ok;
        int bn, lo, ri, nb;
        logic ia;
        logic [15:0] e, g;
        logic [6:0] l;
        repeat (2) @(negedge clock);
        checks++; if (LPF !== 7'b0001000) begin errors++; $display("FAIL reset_lpf: got %b expected 0001000", LPF); end
        checks++; if (tx_inhibit !== 1'b1) begin errors++; $display("FAIL reset_inhibit: got %b expected 1", tx_inhibit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (alex_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", alex_sclk); end
        checks++; if (alex_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", alex_sdo); end
        checks++; if (alex_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", alex_load); end
        exp_q.push_back(16'h0008);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        wait_busy(ok);
        measure(bn, lo, ri, ia);
        checks++; if (bn != TOTAL) begin errors++; $display("FAIL reset_xfer_len: got %0d expected %0d", bn, TOTAL); end
        checks++; if (lo != 0) begin errors++; $display("FAIL reset_inhibit_gap: got %0d low cycles expected 0", lo); end
        checks++; if (ri != 16) begin errors++; $display("FAIL reset_sclk_count: got %0d expected 16", ri); end
        checks++; if (ia !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", ia); end
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL reset_word: got %h (%0d bits) expected %h", g, nb, e); end
        checks++; if (l !== 7'b0001000 || LPF !== 7'b0001000) begin errors++; $display("FAIL reset_word_lpf: got %b/%b expected 0001000", l, LPF); end
    endtask

    task automatic test_band_change;
        bit ok;
        int bn, lo, ri, nb;
        logic ia;
        logic [15:0] e, g;
        logic [6:0] l;
        @(posedge clock); #1 rx_frequency = 32'd14200000;
        exp_q.push_back(16'h0001);
        @(negedge clock);
        @(negedge clock);
        checks++; if (tx_inhibit !== 1'b0) begin errors++; $display("FAIL band_inhibit_early: got %b expected 0", tx_inhibit); end
        @(negedge clock);
        checks++; if (tx_inhibit !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL band_inhibit_rise: got %b/%b expected 1/1", tx_inhibit, busy); end
        measure(bn, lo, ri, ia);
        checks++; if (bn != TOTAL) begin errors++; $display("FAIL band_xfer_len: got %0d expected %0d", bn, TOTAL); end
        checks++; if (lo != 0 || ia !== 1'b0) begin errors++; $display("FAIL band_inhibit: got low=%0d after=%b expected 0/0", lo, ia); end
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL band_word: got %h (%0d bits) expected %h", g, nb, e); end
        checks++; if (l !== 7'b0000001) begin errors++; $display("FAIL band_lpf_at_load: got %b expected 0000001", l); end
    endtask

    task automatic test_boundaries;
        logic [31:0] freqs[4] = '{32'd2000001, 32'd2000000, 32'd29700001, 32'd29700000};
        logic [15:0] words[4] = '{16'h0004, 16'h0008, 16'h0010, 16'h0020};
        bit ok;
        int bn, lo, ri, nb;
        logic ia;
        logic [15:0] e, g;
        logic [6:0] l;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1 rx_frequency = freqs[i];
            exp_q.push_back(words[i]);
            @(negedge clock);
            wait_busy(ok);
            measure(bn, lo, ri, ia);
            checks++; if (bn != TOTAL || lo != 0) begin errors++; $display("FAIL bound_xfer_%0d: got len=%0d low=%0d expected %0d/0", freqs[i], bn, lo, TOTAL); end
            pop_word(ok, e, g, l, nb);
            checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL bound_word_%0d: got %h expected %h", freqs[i], g, e); end
            checks++; if (LPF !== e[6:0]) begin errors++; $display("FAIL bound_lpf_%0d: got %b expected %b", freqs[i], LPF, e[6:0]); end
        end
    endtask

    task automatic test_ptt_mid_shift;
        bit ok, toggled;
        int n, lo, ri, nb;
        logic prev;
        logic [15:0] e, g;
        logic [6:0] l;
        @(posedge clock); #1 rx_frequency = 32'd3600000; tx_frequency = 32'd28400000; ptt = 1'b0;
        exp_q.push_back(16'h0004);
        @(negedge clock);
        wait_busy(ok);
        n = 0; lo = 0; ri = 0; toggled = 1'b0; prev = alex_sclk;
        while (busy && n < LIMIT) begin
            n++;
            if (!tx_inhibit) lo++;
            if (alex_sclk && !prev) ri++;
            prev = alex_sclk;
            if (ri == 4 && !toggled) begin
                toggled = 1'b1;
                ptt = 1'b1;
                exp_q.push_back(16'h0020);
            end
            @(negedge clock);
        end
        checks++; if (n != 2 * TOTAL) begin errors++; $display("FAIL ptt_busy_len: got %0d expected %0d", n, 2 * TOTAL); end
        checks++; if (lo != 0 || tx_inhibit !== 1'b0) begin errors++; $display("FAIL ptt_inhibit: got low=%0d after=%b expected 0/0", lo, tx_inhibit); end
        checks++; if (ri != 32) begin errors++; $display("FAIL ptt_sclk_count: got %0d expected 32", ri); end
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL ptt_word1: got %h expected %h", g, e); end
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL ptt_word2: got %h expected %h", g, e); end
        checks++; if (LPF !== 7'b0100000) begin errors++; $display("FAIL ptt_lpf: got %b expected 0100000", LPF); end
    endtask

    task automatic test_same_band;
        bit ok;
        int bn, lo, ri, nb, nbusy, ninh, nsclk;
        logic ia, prev;
        logic [15:0] e, g;
        logic [6:0] l;
        @(posedge clock); #1 ptt = 1'b0; rx_frequency = 32'd7000000;
        exp_q.push_back(16'h0002);
        @(negedge clock);
        wait_busy(ok);
        measure(bn, lo, ri, ia);
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || bn != TOTAL) begin errors++; $display("FAIL same_first_word: got %h len=%0d expected %h len=%0d", g, bn, e, TOTAL); end
        @(posedge clock); #1 rx_frequency = 32'd7200000;
        nbusy = 0; ninh = 0; nsclk = 0; prev = alex_sclk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy) nbusy++;
            if (tx_inhibit) ninh++;
            if (alex_sclk !== prev) nsclk++;
            prev = alex_sclk;
        end
        checks++; if (nbusy != 0 || ninh != 0 || nsclk != 0) begin errors++; $display("FAIL same_band_quiet: got busy=%0d inhibit=%0d sclk=%0d expected 0/0/0", nbusy, ninh, nsclk); end
        checks++; if (LPF !== 7'b0000010) begin errors++; $display("FAIL same_band_lpf: got %b expected 0000010", LPF); end
    endtask

    task automatic test_reset_mid_shift;
        bit ok;
        int n, ri, bn, lo, nb;
        logic ia, prev;
        logic [15:0] e, g;
        logic [6:0] l;
        @(posedge clock); #1 rx_frequency = 32'd14200000;
        @(negedge clock);
        wait_busy(ok);
        n = 0; ri = 0; prev = alex_sclk;
        while (ri < 9 && n < LIMIT) begin
            if (alex_sclk && !prev) ri++;
            prev = alex_sclk;
            if (ri < 9) begin
                @(negedge clock);
                n++;
            end
        end
        checks++; if (alex_sclk !== 1'b1 || LPF !== 7'b0000010) begin errors++; $display("FAIL rst_mid_pre: got sclk=%b lpf=%b expected 1/0000010", alex_sclk, LPF); end
        #1 reset = 1'b1;
        #1;
        checks++; if (alex_sclk !== 1'b0 || alex_sdo !== 1'b0 || alex_load !== 1'b0) begin errors++; $display("FAIL rst_mid_pins: got %b%b%b expected 000", alex_sclk, alex_sdo, alex_load); end
        checks++; if (LPF !== 7'b0001000 || tx_inhibit !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got lpf=%b inh=%b busy=%b expected 0001000/1/0", LPF, tx_inhibit, busy); end
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b0;
        exp_q.push_back(16'h0001);
        @(negedge clock);
        wait_busy(ok);
        measure(bn, lo, ri, ia);
        checks++; if (bn != TOTAL || lo != 0 || ri != 16 || ia !== 1'b0) begin errors++; $display("FAIL rst_mid_fresh: got len=%0d low=%0d sclk=%0d after=%b expected %0d/0/16/0", bn, lo, ri, ia, TOTAL); end
        pop_word(ok, e, g, l, nb);
        checks++; if (!ok || g !== e || nb != 16) begin errors++; $display("FAIL rst_mid_word: got %h (%0d bits) expected %h", g, nb, e); end
        checks++; if (LPF !== 7'b0000001) begin errors++; $display("FAIL rst_mid_lpf: got %b expected 0000001", LPF); end
    endtask

    task automatic test_drained;
        checks++;
        if (exp_q.size() != 0 || got_word_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d expected / %0d captured left, expected 0/0", exp_q.size(), got_word_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_frequency = 32'd1800000;
        tx_frequency = 32'd0;
        ptt = 1'b0;
        test_reset();
        test_band_change();
        test_boundaries();
        test_ptt_mid_shift();
        test_same_band();
        test_reset_mid_shift();
        test_drained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
